// File: rtl/dem_xuong_4bit.sv
// Presettable modulo-MODULUS down counter: clamped load, cascade borrow, auto-reload or one-shot stop.
// q/done/busy update on the edge after a step; tc is combinational; no backpressure, en&bin gate stepping.
module dem_xuong_4bit #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             en,
  input  logic             bin,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             auto_rl,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             done,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int             WP1     = WIDTH + 1;
  localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = WP1'(MODULUS);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rl_q, rl_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] dv;
  logic             step;
  logic             at_zero;

  // Out-of-range load values saturate so q can never leave 0..MODULUS-1.
  assign dv      = ({1'b0, d} < MOD_EXT) ? d : TOP_VAL;
  assign step    = (state_q == RUN) & en & bin & ~ld;
  assign at_zero = (q_q == '0);
  assign tc      = step & at_zero;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rl_d    = rl_q;
    done_d  = 1'b0;
    if (ld) begin
      q_d     = dv;
      rl_d    = dv;
      state_d = RUN;
    end else if (step) begin
      if (at_zero) begin
        done_d = 1'b1;
        if (auto_rl) begin
          q_d = rl_q;
        end else begin
          state_d = IDLE;
        end
      end else begin
        q_d = q_q - ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      state_q <= IDLE;
      q_q     <= '0;
      rl_q    <= TOP_VAL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rl_q    <= rl_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign done = done_q;
  assign busy = (state_q == RUN);

endmodule

// File: doc/dem_xuong_4bit.md
Name: dem_xuong_4bit

Overview:
- Presettable down counter; the counting-down counterpart to the team's 4-bit up counter.
- Used as a cascadable timer/divider: load a start value, count down on enable, then either reload or stop at zero.
- Borrow-in/borrow-out allow chaining digits, e.g. MODULUS=10 for BCD countdown displays.

Parameters:
- WIDTH, 4, counter width in bits.
- MODULUS, 16, count range 0..MODULUS-1. Must satisfy 2 <= MODULUS <= 2**WIDTH; 10 gives a BCD digit.

Ports:
- clk      input   1      rising-edge clock.
- rs       input   1      asynchronous reset, active-low.
- en       input   1      count enable.
- bin      input   1      borrow-in (cascade enable); tie to 1 on the least-significant stage.
- ld       input   1      synchronous load strobe.
- d        input   WIDTH  load value.
- auto_rl  input   1      1 = reload at terminal count; 0 = one-shot (stop at zero).
- q        output  WIDTH  current count.
- tc       output  1      borrow-out / terminal count (combinational).
- done     output  1      registered one-cycle pulse at each terminal event.
- busy     output  1      1 while in RUN.

Behaviour:
- Reset (rs=0, asynchronous, effective immediately, including mid-count):
  - q=0, rl_reg=MODULUS-1, state=IDLE, done=0, busy=0.
  - Outputs hold these values while rs=0.
- State machine has two states: IDLE and RUN. busy = (state==RUN).
- Load (priority 1, either state):
  - On ld=1: q<=dv and rl_reg<=dv, where dv = d if d<MODULUS, else MODULUS-1 (clamp).
  - state<=RUN. done<=0 that cycle.
  - en, bin and a terminal event in the same cycle are ignored.
- Step condition: step = (state==RUN) & en & bin & !ld.
- RUN, step, q!=0: q<=q-1. No other change.
- RUN, step, q==0 (terminal event):
  - done<=1 for exactly one cycle.
  - auto_rl=1: q<=rl_reg; stay RUN.
  - auto_rl=0: q stays 0; state<=IDLE.
- RUN, no step: hold q. done<=0.
- IDLE:
  - q holds.
  - en/bin have no effect; only ld leaves IDLE.
  - done<=0.
- Terminal count: tc = step & (q==0), combinational.
  - tc drives the next stage's bin, so a chain decrements the upper digit in the same cycle the lower digit wraps.
- Period: loaded value N with auto_rl=1 gives one tc/done every N+1 enabled steps.
  - N=0 gives tc on every step.
- auto_rl is sampled only at the terminal event; changing it mid-count is legal.
- Arithmetic:
  - Decrement is modulo-free because q==0 is intercepted.
  - q never exceeds MODULUS-1, since the load is clamped and the reset value is 0.
- done latency: asserted the cycle after the clock edge where tc=1.

Test Plan:
- Reset then idle: rs=0 mid-count with q=7 -> q=0, busy=0, done=0 immediately without a clock edge; after release with en=1, bin=1 and no ld -> q stays 0, tc=0.
- One-shot: MODULUS=16, ld with d=3, auto_rl=0, en=1, bin=1 -> q=3,2,1,0. On the next step, tc=1; after that edge done=1 for one cycle, busy=0, q=0, and further en is ignored.
- Auto-reload: ld with d=2, auto_rl=1, en held high -> q=2,1,0,2,1,0,... with tc every 3rd cycle and a done pulse one cycle after each tc.
- BCD clamp and cascade: two instances with MODULUS=10; low stage bin=1, high stage bin=low.tc. Load low=d=15 (clamps to 9) and high=2, auto_rl=1. Stepping gives 29, 28, ... 20, 19, ... 00, then reload to 29. High stage decrements only on cycles where low.tc=1.
- Load collisions: in RUN with q=0 and step conditions true, assert ld with d=5 -> q=5, tc=0, no done pulse, busy=1. In IDLE, ld with d=4 -> RUN with q=4.
- Enable gating: in RUN with q=6, toggle en and bin alternately -> q decrements only on cycles where en&bin=1; q holds otherwise and done stays 0.
